sync_fifo_flex: RTL and testbench

- Parametrised next-generation synchronous FIFO for the single-clock datapath.
- Adds non-power-of-two depth, programmable almost-full/almost-empty thresholds, an occupancy output and a selectable first-word-fall-through (FWFT) read mode.
- Optional sticky overflow/underflow error flags.
- Drop-in buffer between producer/consumer blocks sharing clk.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_ram.sv | 40 ++++
 rtl/sync_fifo_flex.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_flex.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for the sync_fifo_flex family: derived widths and the
// explicit wrap-around pointer increment used for non-power-of-two depths.
// No ports (package).
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width, at least one bit.
    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Wraps DEPTH-1 -> 0 explicitly so any depth works, not just powers of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// DEPTH x DATAWIDTH storage for sync_fifo_flex: synchronous write port,
// asynchronous read port (the top registers the read data).
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module sync_fifo_ram #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int ADW       = 3
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADW-1:0]       waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [ADW-1:0]       raddr,
    output logic [DATAWIDTH-1:0] rdata
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; a word is only read after it has been
    // written, and leaving it out lets the array map onto RAM/LUT-RAM.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty
// thresholds, occupancy output and selectable standard / first-word-fall-
// through read mode. Sticky overflow/underflow flags are built only when the
// macro SYNC_FIFO_ERR_EN is defined; otherwise they are tied low.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   wen / din     write request and data (ignored while full)
//   ren           read request / pop of head word (ignored while empty)
//   dout          read data (FWFT: current head word)
//   full, empty   count == DEPTH, count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   err_clr       synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0,
    localparam int CW       = count_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [DATAWIDTH-1:0] din,
    output logic [DATAWIDTH-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [CW-1:0]        count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int ADW = addr_width(DEPTH);

    logic [ADW-1:0]       wptr, rptr, wptr_nxt, rptr_nxt, raddr;
    logic [CW-1:0]        cnt;
    logic                 wr_acc, rd_acc;
    logic [DATAWIDTH-1:0] rdata, dout_q;

    // Flags come straight from the registered count.
    assign full         = (cnt == CW'(DEPTH));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= CW'(AF_THRESH));
    assign almost_empty = (cnt <= CW'(AE_THRESH));
    assign count        = cnt;
    assign dout         = dout_q;

    // Full blocks writes even if a read frees a slot in the same cycle.
    assign wr_acc = wen && !full;
    assign rd_acc = ren && !empty;

    assign wptr_nxt = ADW'(ptr_inc(32'(wptr), DEPTH));
    assign rptr_nxt = ADW'(ptr_inc(32'(rptr), DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_acc) wptr <= wptr_nxt;
            if (rd_acc) rptr <= rptr_nxt;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    sync_fifo_ram #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH),
        .ADW       (ADW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // dout is a prefetch of the head word (which also stays in memory
            // at rptr). On a pop the memory is addressed one ahead, so the
            // next head is ready at the edge. When the FIFO is empty, or about
            // to hold only the incoming word, that word bypasses the memory.
            assign raddr = rptr_nxt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (wr_acc && (empty || (rd_acc && cnt == CW'(1)))) begin
                    dout_q <= din;
                end else if (rd_acc && cnt != CW'(1)) begin
                    dout_q <= rdata;
                end
            end
        end else begin : g_std
            assign raddr = rptr;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= rdata;
                end
            end
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags; a new error in the clear cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && full)  overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (ren && empty) underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
// Three FIFO configurations driven with the same stimulus, each compared
// every cycle against a queue-based reference model:
//   u0: DEPTH=5, AF=4, AE=1, standard read
//   u1: DEPTH=8, AF=6, AE=2, standard read
//   u2: DEPTH=5, default thresholds, FWFT
// -----------------------------------------------------------------------------
module tb_sync_fifo_flex;

    typedef logic [7:0] data_q_t [$];

    localparam int DEP [3] = '{5, 8, 5};
    localparam int AFT [3] = '{4, 6, 4};
    localparam int AET [3] = '{1, 2, 1};
    localparam int FW  [3] = '{0, 0, 1};

`ifdef SYNC_FIFO_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout_w  [3];
    logic       full_w  [3];
    logic       empty_w [3];
    logic       af_w    [3];
    logic       ae_w    [3];
    logic       ovf_w   [3];
    logic       unf_w   [3];
    logic [2:0] count0;
    logic [3:0] count1;
    logic [2:0] count2;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model state
    data_q_t    mq0, mq1, mq2;
    logic [7:0] mdout [3];
    logic       movf  [3];
    logic       munf  [3];

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATAWIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u0 (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren), .din(din), .dout(dout_w[0]),
        .full(full_w[0]), .empty(empty_w[0]), .almost_full(af_w[0]), .almost_empty(ae_w[0]),
        .count(count0), .overflow(ovf_w[0]), .underflow(unf_w[0]), .err_clr(err_clr)
    );

    sync_fifo_flex #(.DATAWIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u1 (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren), .din(din), .dout(dout_w[1]),
        .full(full_w[1]), .empty(empty_w[1]), .almost_full(af_w[1]), .almost_empty(ae_w[1]),
        .count(count1), .overflow(ovf_w[1]), .underflow(unf_w[1]), .err_clr(err_clr)
    );

    sync_fifo_flex #(.DATAWIDTH(8), .DEPTH(5), .FWFT(1)) u2 (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren), .din(din), .dout(dout_w[2]),
        .full(full_w[2]), .empty(empty_w[2]), .almost_full(af_w[2]), .almost_empty(ae_w[2]),
        .count(count2), .overflow(ovf_w[2]), .underflow(unf_w[2]), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int k);
        if (k == 0) return mq0.size();
        if (k == 1) return mq1.size();
        return mq2.size();
    endfunction

    function automatic logic [31:0] cnt_of(input int k);
        if (k == 0) return 32'(count0);
        if (k == 1) return 32'(count1);
        return 32'(count2);
    endfunction

    // One clock of FIFO behaviour, using the current inputs and the
    // pre-edge occupancy to decide what is accepted.
    task automatic model_one(input int k, input data_q_t qi, output data_q_t qo);
        logic       is_full, is_empty;
        logic [7:0] popped;
        qo       = qi;
        is_full  = (qo.size() == DEP[k]);
        is_empty = (qo.size() == 0);
`ifdef SYNC_FIFO_ERR_EN
        if (wen && is_full) movf[k] = 1'b1;
        else if (err_clr)   movf[k] = 1'b0;
        if (ren && is_empty) munf[k] = 1'b1;
        else if (err_clr)    munf[k] = 1'b0;
`endif
        if (ren && !is_empty) begin
            popped = qo.pop_front();
            if (FW[k] == 0) mdout[k] = popped;
        end
        if (wen && !is_full) qo.push_back(din);
        if (FW[k] != 0 && qo.size() != 0) mdout[k] = qo[0];
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        mq2.delete();
        for (int k = 0; k < 3; k++) begin
            mdout[k] = 8'h00;
            movf[k]  = 1'b0;
            munf[k]  = 1'b0;
        end
    endtask

    task automatic check_all();
        int         sz;
        logic [5:0] exp_flags, obs_flags;
        for (int k = 0; k < 3; k++) begin
            sz        = qsize(k);
            exp_flags = {sz == DEP[k], sz == 0, sz >= AFT[k], sz <= AET[k], movf[k], munf[k]};
            obs_flags = {full_w[k], empty_w[k], af_w[k], ae_w[k], ovf_w[k], unf_w[k]};
            check($sformatf("u%0d.dout c%0d", k, cyc), 32'(dout_w[k]), 32'(mdout[k]));
            check($sformatf("u%0d.count c%0d", k, cyc), cnt_of(k), 32'(sz));
            check($sformatf("u%0d.flags{f,e,af,ae,ov,un} c%0d", k, cyc), 32'(obs_flags), 32'(exp_flags));
        end
    endtask

    // Called at a falling edge: drive, advance the model, clock, check.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic c);
        data_q_t tmp;
        wen     = w;
        ren     = r;
        din     = d;
        err_clr = c;
        model_one(0, mq0, tmp); mq0 = tmp;
        model_one(1, mq1, tmp); mq1 = tmp;
        model_one(2, mq2, tmp); mq2 = tmp;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    // Asynchronous reset pulse held across one rising edge; whatever
    // write is on the inputs at that edge must be lost.
    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        int pw;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        check("reset_almost_empty", 32'(ae_w[0]), 32'd1);
        rst = 1'b1;

        // Fill DEPTH=5 and overrun it.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 8'(8'h11 * i), 1'b0);
        check("full_after_5", 32'(full_w[0]), 32'd1);
        cycle(1'b1, 1'b0, 8'h66, 1'b0);
        check("count_after_extra", 32'(count0), 32'd5);
        check("overflow_set", 32'(ovf_w[0]), 32'(ERR_EXP));

        // Drain in order, one cycle of latency.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            check($sformatf("dout_seq%0d", i), 32'(dout_w[0]), 32'(8'h11 * i));
        end
        check("empty_after_drain", 32'(empty_w[0]), 32'd1);

        // Pointer wrap 4 -> 0.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h21 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h31 + i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("wrap_last_dout", 32'(dout_w[0]), 32'h34);
        check("wrap_count_zero", 32'(count0), 32'd0);

        // Empty everything, clear errors.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous write+read while full: only the read lands.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h41 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        check("full_wr_rd_count", 32'(count0), 32'd4);
        check("full_wr_rd_dout", 32'(dout_w[0]), 32'h41);

        // Simultaneous write+read while empty: only the write lands.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 8'h88, 1'b0);
        check("empty_wr_rd_count", 32'(count0), 32'd1);
        check("underflow_set", 32'(unf_w[0]), 32'(ERR_EXP));
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("err_clr_ovf", 32'(ovf_w[0]), 32'd0);
        check("err_clr_unf", 32'(unf_w[0]), 32'd0);

        // FWFT: write into empty shows up without a read.
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'hA5, 1'b0);
        check("fwft_first_word", 32'(dout_w[2]), 32'hA5);
        check("fwft_not_empty", 32'(empty_w[2]), 32'd0);
        cycle(1'b1, 1'b1, 8'h5A, 1'b0);
        check("fwft_cnt1_count", 32'(count2), 32'd1);
        check("fwft_cnt1_dout", 32'(dout_w[2]), 32'h5A);

        // Reset mid-burst at count 4 with a write in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hC1 + i), 1'b0);
        check("pre_reset_count", 32'(count2), 32'd4);
        wen = 1'b1;
        din = 8'hEE;
        pulse_reset();
        check("post_reset_dout", 32'(dout_w[2]), 32'h00);
        check("post_reset_empty", 32'(empty_w[2]), 32'd1);
        cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        check("post_reset_fwft", 32'(dout_w[2]), 32'h3C);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("post_reset_std", 32'(dout_w[0]), 32'h3C);

        // Randomised traffic with phases biased toward full, empty and balanced.
        for (int i = 0; i < 3000; i++) begin
            case ((i / 150) % 3)
                0:       pw = 75;
                1:       pw = 25;
                default: pw = 50;
            endcase
            if ($urandom_range(0, 499) == 0) begin
                wen = 1'($urandom_range(0, 1));
                din = 8'($urandom);
                pulse_reset();
            end else begin
                cycle(1'($urandom_range(0, 99) < pw),
                      1'($urandom_range(0, 99) < (100 - pw)),
                      8'($urandom),
                      1'($urandom_range(0, 31) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
